// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
// Valid/ready request channel, valid-only response channel.
interface load_store_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [3:0]      req_wstrb;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_wstrb,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_wstrb,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one memory transaction at a time, stalls the core while busy,
// returns aligned and extended load data.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (flag misaligned H/W accesses and
// complete them without touching the bus).
// XLEN must be 32: the byte-lane logic is fixed at four lanes.
module load_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_b_i,
    input  logic              lsu_valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        mem_opcode_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   rs2_rdata_i,
    output logic              lsu_stall_o,
    output logic              lsu_done_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              lsu_misalign_o,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

    state_e          state_q;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      opcode_q;
    logic            write_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic            req_valid_q;
    logic            done_q;
    logic            misalign_q;
    logic [XLEN-1:0] rdata_q;

    logic            accept;
    logic            is_write;
    logic            misalign_d;
    logic [XLEN-1:0] wdata_d;
    logic [3:0]      wstrb_d;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            ld_signed;
    logic [XLEN-1:0] load_data;

    // Read wins when both direction bits are set.
    assign accept   = lsu_valid_i & (mem_read_i | mem_write_i);
    assign is_write = mem_write_i & ~mem_read_i;

    // Store lane replication/strobes and misalignment detection for the incoming access.
    always_comb begin
        wdata_d    = rs2_rdata_i;
        wstrb_d    = 4'b1111;
        misalign_d = 1'b0;
        unique case (mem_opcode_i[1:0])
            2'b00: begin
                wdata_d = {4{rs2_rdata_i[7:0]}};
                wstrb_d = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                wdata_d = {2{rs2_rdata_i[15:0]}};
                wstrb_d = 4'b0011 << {alu_result_i[1], 1'b0};
`ifdef LSU_MISALIGN_CHECK_EN
                misalign_d = alu_result_i[0];
`endif
            end
            default: begin
`ifdef LSU_MISALIGN_CHECK_EN
                misalign_d = (alu_result_i[1:0] != 2'b00);
`endif
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the word-aligned read data.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    ld_byte = bus.rsp_rdata[7:0];
            2'd1:    ld_byte = bus.rsp_rdata[15:8];
            2'd2:    ld_byte = bus.rsp_rdata[23:16];
            default: ld_byte = bus.rsp_rdata[31:24];
        endcase
        ld_half   = addr_q[1] ? bus.rsp_rdata[31:16] : bus.rsp_rdata[15:0];
        ld_signed = ~opcode_q[2];
        unique case (opcode_q[1:0])
            2'b00:   load_data = {{(XLEN-8){ld_signed & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{(XLEN-16){ld_signed & ld_half[15]}}, ld_half};
            default: load_data = bus.rsp_rdata;
        endcase
    end

    // Transaction FSM; all bus and completion outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            opcode_q    <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q   <= alu_result_i;
                        opcode_q <= mem_opcode_i;
                        write_q  <= is_write;
                        wdata_q  <= wdata_d;
                        wstrb_q  <= is_write ? wstrb_d : 4'b0000;
                        if (misalign_d) begin
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (bus.req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (bus.rsp_valid) begin
                        if (!write_q) begin
                            rdata_q <= load_data;
                        end
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign lsu_stall_o    = ((state_q == StIdle) && accept) || (state_q == StReq) ||
                            (state_q == StRsp);
    assign lsu_done_o     = done_q;
    assign lsu_rdata_o    = rdata_q;
    assign lsu_misalign_o = misalign_q;

    assign bus.req_valid = req_valid_q;
    assign bus.req_write = write_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_wdata = wdata_q;
    assign bus.req_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of zero-wait transactions plus
// hand-written sequences for wait states, misalignment and mid-transaction reset.
module tb_load_store_unit;

    logic        clk;
    logic        rst_b;
    logic        lsu_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_opcode;
    logic [31:0] alu_result;
    logic [31:0] rs2_rdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;

    int n_cmp  = 0;
    int n_fail = 0;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32)) dut (
        .clk_i          (clk),
        .rst_b_i        (rst_b),
        .lsu_valid_i    (lsu_valid),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .mem_opcode_i   (mem_opcode),
        .alu_result_i   (alu_result),
        .rs2_rdata_i    (rs2_rdata),
        .lsu_stall_o    (lsu_stall),
        .lsu_done_o     (lsu_done),
        .lsu_rdata_o    (lsu_rdata),
        .lsu_misalign_o (lsu_misalign),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rsp;
        logic        exp_write;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait transaction: accept c0, REQ c1, RSP c2, DONE c3.
    task automatic run_vec(input vec_t v, input string tag);
        lsu_valid  = 1'b1;
        mem_read   = v.rd;
        mem_write  = v.wr;
        mem_opcode = v.op;
        alu_result = v.addr;
        rs2_rdata  = v.rs2;
        @(negedge clk);
        chk({tag, ".stall_c0"}, 32'(lsu_stall), 32'd1);
        tick();
        lsu_valid     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        bus.req_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".req_valid_c1"}, 32'(bus.req_valid), 32'd1);
        chk({tag, ".req_write"}, 32'(bus.req_write), 32'(v.exp_write));
        chk({tag, ".req_addr"}, bus.req_addr, v.addr);
        chk({tag, ".req_wstrb"}, 32'(bus.req_wstrb), 32'(v.exp_wstrb));
        if (v.exp_write) chk({tag, ".req_wdata"}, bus.req_wdata, v.exp_wdata);
        chk({tag, ".stall_c1"}, 32'(lsu_stall), 32'd1);
        tick();
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = v.rsp;
        @(negedge clk);
        chk({tag, ".req_valid_c2"}, 32'(bus.req_valid), 32'd0);
        chk({tag, ".stall_c2"}, 32'(lsu_stall), 32'd1);
        chk({tag, ".done_c2"}, 32'(lsu_done), 32'd0);
        tick();
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        @(negedge clk);
        chk({tag, ".done_c3"}, 32'(lsu_done), 32'd1);
        chk({tag, ".stall_c3"}, 32'(lsu_stall), 32'd0);
        chk({tag, ".misalign_c3"}, 32'(lsu_misalign), 32'd0);
        chk({tag, ".rdata"}, lsu_rdata, v.exp_rdata);
        tick();
        @(negedge clk);
        chk({tag, ".done_c4"}, 32'(lsu_done), 32'd0);
        tick();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        //           rd    wr    op      addr          rs2           rsp           wr    wdata         wstrb    rdata
        vecs[0] = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0,        4'b0000, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 32'h0,        4'b0000, 32'hFFFF_FF80};
        vecs[2] = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 32'h0,        4'b0000, 32'h0000_0080};
        vecs[3] = '{1'b0, 1'b1, 3'b000, 32'h0000_0202, 32'h0000_00A5, 32'h0,        1'b1, 32'hA5A5_A5A5, 4'b0100, 32'h0000_0080};
        vecs[4] = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b0, 32'h0,        4'b0000, 32'hFFFF_8001};
        vecs[5] = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_F234, 1'b0, 32'h0,        4'b0000, 32'h0000_F234};
        vecs[6] = '{1'b0, 1'b1, 3'b001, 32'h0000_0306, 32'h1234_BEEF, 32'h0,        1'b1, 32'hBEEF_BEEF, 4'b1100, 32'h0000_F234};
        vecs[7] = '{1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0000_F234};
        vecs[8] = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1'b0, 32'h0,        4'b0000, 32'h0000_007F};
        vecs[9] = '{1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'h0,        4'b0000, 32'h1234_5678};

        rst_b         = 1'b0;
        lsu_valid     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_opcode    = 3'b000;
        alu_result    = 32'h0;
        rs2_rdata     = 32'h0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;

        // Reset state.
        #2;
        chk("rst.req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst.req_write", 32'(bus.req_write), 32'd0);
        chk("rst.req_addr", bus.req_addr, 32'h0);
        chk("rst.req_wdata", bus.req_wdata, 32'h0);
        chk("rst.req_wstrb", 32'(bus.req_wstrb), 32'd0);
        chk("rst.done", 32'(lsu_done), 32'd0);
        chk("rst.misalign", 32'(lsu_misalign), 32'd0);
        chk("rst.stall", 32'(lsu_stall), 32'd0);
        chk("rst.rdata", lsu_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // SH at 0x300: ready low 4 cycles, stray responses in REQ, response 2 cycles after ready.
        lsu_valid  = 1'b1;
        mem_write  = 1'b1;
        mem_opcode = 3'b001;
        alu_result = 32'h0000_0300;
        rs2_rdata  = 32'h0000_BEEF;
        @(negedge clk);
        chk("wait.stall_c0", 32'(lsu_stall), 32'd1);
        tick();
        lsu_valid = 1'b0;
        mem_write = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            bus.req_ready = (c == 5);
            bus.rsp_valid = (c == 2) || (c == 5);
            bus.rsp_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk($sformatf("wait.req_valid_c%0d", c), 32'(bus.req_valid), 32'd1);
            chk($sformatf("wait.req_addr_c%0d", c), bus.req_addr, 32'h0000_0300);
            chk($sformatf("wait.req_wdata_c%0d", c), bus.req_wdata, 32'hBEEF_BEEF);
            chk($sformatf("wait.req_wstrb_c%0d", c), 32'(bus.req_wstrb), 32'b0011);
            chk($sformatf("wait.req_write_c%0d", c), 32'(bus.req_write), 32'd1);
            chk($sformatf("wait.done_c%0d", c), 32'(lsu_done), 32'd0);
            tick();
        end
        bus.req_ready = 1'b0;
        for (int c = 6; c <= 7; c++) begin
            bus.rsp_valid = (c == 7);
            @(negedge clk);
            chk($sformatf("wait.req_valid_c%0d", c), 32'(bus.req_valid), 32'd0);
            chk($sformatf("wait.stall_c%0d", c), 32'(lsu_stall), 32'd1);
            chk($sformatf("wait.done_c%0d", c), 32'(lsu_done), 32'd0);
            tick();
        end
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        chk("wait.done_c8", 32'(lsu_done), 32'd1);
        chk("wait.stall_c8", 32'(lsu_stall), 32'd0);
        chk("wait.rdata_kept", lsu_rdata, 32'h1234_5678);
        tick();
        tick();

`ifdef LSU_MISALIGN_CHECK_EN
        // Misaligned LW: completes in one cycle with no bus request.
        lsu_valid  = 1'b1;
        mem_read   = 1'b1;
        mem_opcode = 3'b010;
        alu_result = 32'h0000_0101;
        @(negedge clk);
        chk("mis.stall_c0", 32'(lsu_stall), 32'd1);
        tick();
        lsu_valid = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        chk("mis.done_c1", 32'(lsu_done), 32'd1);
        chk("mis.misalign_c1", 32'(lsu_misalign), 32'd1);
        chk("mis.req_valid_c1", 32'(bus.req_valid), 32'd0);
        chk("mis.stall_c1", 32'(lsu_stall), 32'd0);
        chk("mis.rdata_kept", lsu_rdata, 32'h1234_5678);
        tick();
        @(negedge clk);
        chk("mis.done_c2", 32'(lsu_done), 32'd0);
        chk("mis.misalign_c2", 32'(lsu_misalign), 32'd0);
        chk("mis.req_valid_c2", 32'(bus.req_valid), 32'd0);
        tick();
`else
        // Without the check, unaligned accesses go to the bus with simplified lanes.
        begin
            vec_t mv;
            mv = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0BAD_F00D, 1'b0, 32'h0,
                   4'b0000, 32'h0BAD_F00D};
            run_vec(mv, "nomis_lw");
            mv = '{1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h0000_ABCD, 32'h0, 1'b1,
                   32'hABCD_ABCD, 4'b0011, 32'h0BAD_F00D};
            run_vec(mv, "nomis_sh");
        end
`endif

        // Reset while the request is pending in REQ.
        lsu_valid  = 1'b1;
        mem_read   = 1'b1;
        mem_opcode = 3'b010;
        alu_result = 32'h0000_0200;
        tick();
        lsu_valid = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        chk("rstreq.req_valid_before", 32'(bus.req_valid), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rstreq.req_valid", 32'(bus.req_valid), 32'd0);
        chk("rstreq.stall", 32'(lsu_stall), 32'd0);
        tick();
        rst_b = 1'b1;
        tick();

        // Reset while waiting in RSP; a late response must not complete anything.
        lsu_valid  = 1'b1;
        mem_read   = 1'b1;
        mem_opcode = 3'b010;
        alu_result = 32'h0000_0204;
        tick();
        lsu_valid     = 1'b0;
        mem_read      = 1'b0;
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        @(negedge clk);
        chk("rstrsp.stall_before", 32'(lsu_stall), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("rstrsp.req_valid", 32'(bus.req_valid), 32'd0);
        chk("rstrsp.stall", 32'(lsu_stall), 32'd0);
        chk("rstrsp.done", 32'(lsu_done), 32'd0);
        chk("rstrsp.rdata", lsu_rdata, 32'h0);
        tick();
        rst_b         = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'h5555_AAAA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("late.done_%0d", c), 32'(lsu_done), 32'd0);
            chk($sformatf("late.stall_%0d", c), 32'(lsu_stall), 32'd0);
            tick();
            bus.rsp_valid = (c == 0);
        end
        @(negedge clk);
        chk("late.rdata", lsu_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
